sonar_scheduler: RTL
====================

Name: sonar_scheduler

Overview:
Sequences a bank of ultrasonic range sensors round-robin, so that no two sensors fire at once and cross-talk is avoided. For each sensor in turn it issues the trigger pulse, measures the echo width in microseconds with timeouts, and converts the width to centimetres. It publishes a tagged distance result and keeps a per-sensor obstacle flag. It sits between the sensor pins and the car's steering/motor decision logic. Clock is 100 MHz.

Parameters:
NUM_SENSORS, 3, number of sensors served (2..8)
CLK_PER_US, 100, clk cycles per microsecond tick
TRIG_US, 10, trigger pulse width in us
TIMEOUT_US, 30000, max wait for echo rise and max echo width, in us
GAP_US, 10000, idle settle time after each sensor before the next trigger, in us
IDW, $clog2(NUM_SENSORS), sensor index width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  run the scan while high
thresh_cm  in  10  obstacle threshold in cm
echo  in  NUM_SENSORS  raw echo pins, asynchronous
trig  out  NUM_SENSORS  trigger pins, one-hot or zero
dist_valid  out  1  one-cycle result strobe
dist_id  out  IDW  sensor index of the result
dist_cm  out  16  distance in cm; 16'hFFFF on timeout
dist_timeout  out  1  result is a timeout
obstacle  out  NUM_SENSORS  per-sensor sticky-until-next-result flag
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, idx 0, prescaler 0, counters 0, sync flops 0.
- Echo sync: two-flop synchroniser per bit. Edge detection runs on the synchronised bit of the current idx only.
- us tick: the prescaler counts 0..CLK_PER_US-1, and tick is high at terminal count. The prescaler is cleared on every state transition, so each state's first tick comes exactly CLK_PER_US clocks after entry.
- States:
  - IDLE: if enable, go to TRIG next clk.
  - TRIG: trig[idx]=1 for exactly TRIG_US*CLK_PER_US clocks, then go to WAIT_RISE. trig is a registered output.
  - WAIT_RISE: on a rising edge, clear us_cnt and go to MEASURE. If TIMEOUT_US ticks elapse first, go to REPORT with timeout=1. A level already high on entry is not a rise.
  - MEASURE: us_cnt += 1 per tick. On a falling edge, go to REPORT with timeout=0. If us_cnt reaches TIMEOUT_US, go to REPORT with timeout=1.
  - REPORT: one cycle.
    - Register dist_id=idx, dist_timeout, dist_valid=1 (visible the following cycle for exactly one clk).
    - dist_cm = timeout ? 16'hFFFF : (us_cnt*1115)>>16. The 1115/65536 factor (0.01701 cm/us) approximates 343 m/s round trip.
    - Product width is at least 32 bits; truncate the result to 16 bits.
    - obstacle[idx] = !timeout && dist_cm < thresh_cm. Other obstacle bits are held.
  - GAP: wait GAP_US ticks. Then idx = (idx==NUM_SENSORS-1) ? 0 : idx+1. Go to TRIG if enable, else IDLE.
- Enable low mid-scan: the current sensor completes through REPORT and GAP, then the FSM goes to IDLE. A measurement is never aborted.
- Rise and fall in the same sampled cycle are impossible after sync. A glitch shorter than one clk may be missed; this is acceptable.
- Echo on non-selected sensors is ignored.
- rst mid-operation: immediate return to reset values; trig drops asynchronously.
- busy = (state != IDLE).

Decomposition:
- Shared package sonar_pkg: state enum (IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP), DIST_TIMEOUT=16'hFFFF, CM_MULT=1115, CM_SHIFT=16.
- One sub-module sonar_us_tick: prescaler with synchronous clear input and tick output.
- Synchroniser and FSM stay in the top module.

Test Plan:
- enable=1, sensor 0 echo high 5800 us starting 100 us after trig falls -> trig[0] high exactly 1000 clk; dist_valid once with dist_id=0, dist_cm=98, dist_timeout=0.
- thresh_cm=20, sensor 1 echo 580 us -> dist_cm=9, obstacle[1]=1. Then a 5800 us echo on sensor 1 next round -> obstacle[1]=0.
- Sensor 2 echo never rises -> result after 30000 us in WAIT_RISE with dist_cm=16'hFFFF, dist_timeout=1, obstacle[2]=0. The next trig is trig[0] after the 10000 us gap.
- Sensor 0 echo held high for 40000 us -> timeout result when us_cnt=30000. Sensor 0 echo already high at WAIT_RISE entry is not counted.
- enable dropped during MEASURE of sensor 1 -> result still reported, GAP completes, state IDLE, busy=0, no further trig. Re-enable -> trig[2] fires next.
- Assert rst during TRIG -> trig=0 in the same cycle. After release, idx=0, all outputs 0, and the scan restarts from sensor 0 on enable.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types and constants for the round-robin ultrasonic sonar scheduler.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    REPORT    = 3'd4,
    GAP       = 3'd5
  } sonar_state_t;

  localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;
  localparam int          CM_MULT      = 1115;
  localparam int          CM_SHIFT     = 16;

  // 1115/65536 cm per us approximates the 343 m/s round trip.
  function automatic logic [15:0] us_to_cm(input logic [15:0] us);
    logic [31:0] prod;
    prod = {16'd0, us} * 32'(CM_MULT);
    return prod[CM_SHIFT +: 16];
  endfunction

endpackage

// File: rtl/sonar_us_tick.sv
// Microsecond prescaler: tick at terminal count, restartable by a synchronous clear.
module sonar_us_tick #(
  parameter int CLK_PER_US = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int            PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_PER_US - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == TC)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == TC);

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic range sequencer: trigger, echo timing, cm conversion,
// tagged result strobe and per-sensor obstacle flags.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int NUM_SENSORS = 3,
  parameter int CLK_PER_US  = 100,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 30000,
  parameter int GAP_US      = 10000,
  parameter int IDW         = $clog2(NUM_SENSORS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [9:0]             thresh_cm,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   dist_valid,
  output logic [IDW-1:0]         dist_id,
  output logic [15:0]            dist_cm,
  output logic                   dist_timeout,
  output logic [NUM_SENSORS-1:0] obstacle,
  output logic                   busy
);

  localparam logic [15:0]    TRIG_END = 16'(TRIG_US - 1);
  localparam logic [15:0]    TO_END   = 16'(TIMEOUT_US - 1);
  localparam logic [15:0]    GAP_END  = 16'(GAP_US - 1);
  localparam logic [IDW-1:0] IDX_LAST = IDW'(NUM_SENSORS - 1);

  sonar_state_t           r_state, w_next;
  logic [NUM_SENSORS-1:0] r_sync1, r_sync2, r_trig, r_obstacle, w_trig_next;
  logic                   r_prev, r_timeout, r_dist_valid, r_dist_timeout;
  logic [IDW-1:0]         r_idx, w_idx_next, r_dist_id;
  logic [15:0]            r_us_cnt, r_dist_cm, w_cm;
  logic                   w_tick, w_change, w_to, w_sel, w_rise, w_fall;

  assign w_sel    = r_sync2[r_idx];
  assign w_rise   = w_sel & ~r_prev;
  assign w_fall   = ~w_sel & r_prev;
  assign w_change = (w_next != r_state);
  assign w_cm     = r_timeout ? DIST_TIMEOUT : us_to_cm(r_us_cnt);

  sonar_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_change),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_to   = 1'b0;
    case (r_state)
      IDLE:      if (enable) w_next = TRIG;
      TRIG:      if (w_tick && (r_us_cnt == TRIG_END)) w_next = WAIT_RISE;
      WAIT_RISE: begin
        if (w_rise) begin
          w_next = MEASURE;
        end else if (w_tick && (r_us_cnt == TO_END)) begin
          w_next = REPORT;
          w_to   = 1'b1;
        end
      end
      MEASURE: begin
        if (w_fall) begin
          w_next = REPORT;
        end else if (w_tick && (r_us_cnt == TO_END)) begin
          w_next = REPORT;
          w_to   = 1'b1;
        end
      end
      REPORT:    w_next = GAP;
      GAP:       if (w_tick && (r_us_cnt == GAP_END)) w_next = enable ? TRIG : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Index advance and trigger pattern are computed for the state being entered.
  always_comb begin
    w_idx_next  = r_idx;
    w_trig_next = '0;
    if ((r_state == GAP) && w_change) begin
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
    if (w_next == TRIG) begin
      w_trig_next[w_idx_next] = 1'b1;
    end
  end

  // The count survives into REPORT so a tick coinciding with the fall still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= 1'b0;
      r_us_cnt  <= '0;
      r_idx     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_sync1 <= echo;
      r_sync2 <= r_sync1;
      r_prev  <= w_sel;
      r_idx   <= w_idx_next;
      if (w_change && (w_next != REPORT)) begin
        r_us_cnt <= '0;
      end else if (w_tick) begin
        r_us_cnt <= r_us_cnt + 16'd1;
      end
      if (w_change && (w_next == REPORT)) begin
        r_timeout <= w_to;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig         <= '0;
      r_dist_valid   <= 1'b0;
      r_dist_id      <= '0;
      r_dist_cm      <= '0;
      r_dist_timeout <= 1'b0;
      r_obstacle     <= '0;
    end else begin
      r_trig       <= w_trig_next;
      r_dist_valid <= (r_state == REPORT);
      if (r_state == REPORT) begin
        r_dist_id         <= r_idx;
        r_dist_cm         <= w_cm;
        r_dist_timeout    <= r_timeout;
        r_obstacle[r_idx] <= ~r_timeout && (w_cm < {6'd0, thresh_cm});
      end
    end
  end

  assign trig         = r_trig;
  assign dist_valid   = r_dist_valid;
  assign dist_id      = r_dist_id;
  assign dist_cm      = r_dist_cm;
  assign dist_timeout = r_dist_timeout;
  assign obstacle     = r_obstacle;
  assign busy         = (r_state != IDLE);

endmodule
